// File: rtl/sc_match_pkg.sv
// Shared types and helpers for the match serializer.
//   TIME_W_DEF / DT_W_DEF / N_CH_DEF / DEPTH_DEF : default block parameters
//   rec_t   : one serialized record {channel, signed dt} at default widths
//   sat_dt(): clamp a signed difference to a dt_w-bit signed range
package sc_match_pkg;

    localparam int TIME_W_DEF = 16;
    localparam int DT_W_DEF   = 16;
    localparam int N_CH_DEF   = 37;
    localparam int DEPTH_DEF  = 8;
    localparam int CH_W_DEF   = $clog2(N_CH_DEF);

    typedef struct packed {
        logic [CH_W_DEF-1:0]        ch;
        logic signed [DT_W_DEF-1:0] dt;
    } rec_t;

    // diff arrives already sign-extended to 32 bits; the caller truncates the
    // result to dt_w bits, which is lossless once clamped.
    function automatic logic [31:0] sat_dt(input logic signed [31:0] diff,
                                           input int unsigned        dt_w);
        logic signed [31:0] hi;
        logic signed [31:0] lo;
        hi = (32'sd1 <<< (dt_w - 1)) - 32'sd1;
        lo = -(32'sd1 <<< (dt_w - 1));
        if (diff > hi)
            return hi;
        else if (diff < lo)
            return lo;
        else
            return diff;
    endfunction

endpackage

// File: rtl/sc_match_fifo.sv
// Synchronous show-ahead FIFO holding packed {ch, dt} records.
//   clk, rst_n     : clock, synchronous active-low reset
//   flush          : synchronous clear (same effect as reset)
//   push/push_data : write request; ignored when full unless a pop happens too
//   pop            : consume the head; ignored when empty
//   valid          : head holds a record
//   head_data      : head record, or the last popped record while empty
//   full, level    : occupancy status
module sc_match_fifo
    import sc_match_pkg::*;
#(
    parameter int W     = 22,
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         flush,
    input  logic                         push,
    input  logic [W-1:0]                 push_data,
    input  logic                         pop,
    output logic                         valid,
    output logic [W-1:0]                 head_data,
    output logic                         full,
    output logic [$clog2(DEPTH+1)-1:0]   level
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]   wr_ptr_q, wr_ptr_d;
    logic [AW:0]   rd_ptr_q, rd_ptr_d;
    logic [W-1:0]  last_q, last_d;
    logic [W-1:0]  mem_q [DEPTH];
    logic [AW:0]   count;
    logic          empty;
    logic          do_push;
    logic          do_pop;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign count     = wr_ptr_q - rd_ptr_q;
    assign empty     = (wr_ptr_q == rd_ptr_q);
    assign full      = (count == (AW+1)'(DEPTH));
    assign level     = count;
    assign valid     = !empty;
    assign do_pop    = pop && !empty;
    assign do_push   = push && (!full || do_pop);
    // While empty the outputs keep showing the record that was popped last.
    assign head_data = empty ? last_q : mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        last_d   = last_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            last_d   = '0;
        end else begin
            if (do_push)
                wr_ptr_d = wr_ptr_q + 1'b1;
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
                last_d   = mem_q[rd_ptr_q[AW-1:0]];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            last_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            last_q   <= last_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush)
            mem_q[wr_ptr_q[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/sc_match_serializer_fifo.sv
// Serializes per-channel match events into a {channel, signed dt} stream.
//   clk, rst_n       : clock, synchronous active-low reset
//   flush            : clears pending set and FIFO, keeps drop_cnt
//   song_time        : current song time
//   match_trigger    : one-cycle pulse per channel on a match
//   match_time       : per-channel note time, ch i at [i*TIME_W +: TIME_W]
//   out_valid/ready  : head-of-FIFO handshake
//   out_ch, out_dt   : head record (held while out_valid=0)
//   pending_any      : at least one captured match not yet queued
//   fifo_level       : FIFO occupancy
//   drop_cnt         : saturating count of retriggers lost while pending
module sc_match_serializer_fifo
    import sc_match_pkg::*;
#(
    parameter int N_CH   = N_CH_DEF,
    parameter int TIME_W = TIME_W_DEF,
    parameter int DT_W   = DT_W_DEF,
    parameter int DEPTH  = DEPTH_DEF
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        flush,
    input  logic [TIME_W-1:0]           song_time,
    input  logic [N_CH-1:0]             match_trigger,
    input  logic [N_CH*TIME_W-1:0]      match_time,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [$clog2(N_CH)-1:0]     out_ch,
    output logic signed [DT_W-1:0]      out_dt,
    output logic                        pending_any,
    output logic [$clog2(DEPTH+1)-1:0]  fifo_level,
    output logic [15:0]                 drop_cnt
);

    localparam int CH_W = $clog2(N_CH);

    logic [N_CH-1:0]            pending_q, pending_d;
    logic [N_CH-1:0][DT_W-1:0]  dt_q, dt_d;
    logic [15:0]                drop_cnt_q, drop_cnt_d;
    logic [N_CH-1:0][DT_W-1:0]  cap_dt;
    logic [CH_W-1:0]            sel;
    logic [DT_W-1:0]            sel_dt;
    logic                       sel_valid;
    logic                       fifo_full;
    logic                       push;
    logic [CH_W+DT_W-1:0]       head_data;
    int unsigned                n_drop;
    logic [31:0]                drop_sum;

    // Difference is taken modulo 2^TIME_W and read as signed, so it stays
    // correct across song_time wrap, then clamped to the dt range.
    always_comb begin
        cap_dt = '0;
        for (int i = 0; i < N_CH; i++) begin
            cap_dt[i] = DT_W'(sat_dt(32'(signed'(TIME_W'(song_time -
                              match_time[i*TIME_W +: TIME_W]))), DT_W));
        end
    end

    // Ascending scan: the last pending index seen is the highest one.
    always_comb begin
        sel       = '0;
        sel_dt    = '0;
        sel_valid = 1'b0;
        for (int i = 0; i < N_CH; i++) begin
            if (pending_q[i]) begin
                sel       = CH_W'(i);
                sel_dt    = dt_q[i];
                sel_valid = 1'b1;
            end
        end
    end

    assign push = sel_valid && !flush && (!fifo_full || (out_valid && out_ready));

    always_comb begin
        pending_d = pending_q;
        dt_d      = dt_q;
        n_drop    = 0;
        for (int i = 0; i < N_CH; i++) begin
            // The channel leaving for the FIFO this edge is free to recapture.
            if (push && sel == CH_W'(i))
                pending_d[i] = 1'b0;
            if (match_trigger[i]) begin
                if (pending_q[i] && !(push && sel == CH_W'(i))) begin
                    n_drop = n_drop + 1;
                end else begin
                    pending_d[i] = 1'b1;
                    dt_d[i]      = cap_dt[i];
                end
            end
        end
        if (flush) begin
            pending_d = '0;
            n_drop    = 0;
        end
        drop_sum   = 32'(drop_cnt_q) + n_drop;
        drop_cnt_d = (drop_sum > 32'h0000_FFFF) ? 16'hFFFF : drop_sum[15:0];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pending_q  <= '0;
            dt_q       <= '0;
            drop_cnt_q <= '0;
        end else begin
            pending_q  <= pending_d;
            dt_q       <= dt_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    sc_match_fifo #(
        .W     (CH_W + DT_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .push      (push),
        .push_data ({sel, sel_dt}),
        .pop       (out_ready),
        .valid     (out_valid),
        .head_data (head_data),
        .full      (fifo_full),
        .level     (fifo_level)
    );

    assign out_ch      = head_data[CH_W+DT_W-1:DT_W];
    assign out_dt      = head_data[DT_W-1:0];
    assign pending_any = |pending_q;
    assign drop_cnt    = drop_cnt_q;

endmodule

// File: tb/tb_sc_match_serializer_fifo.sv
module tb_sc_match_serializer_fifo;

    localparam int N_CH   = 37;
    localparam int TIME_W = 16;
    localparam int DT_W   = 8;
    localparam int DEPTH  = 8;

    logic                       clk = 1'b0;
    logic                       rst_n;
    logic                       flush;
    logic [TIME_W-1:0]          song_time;
    logic [N_CH-1:0]            match_trigger;
    logic [N_CH*TIME_W-1:0]     match_time;
    logic                       out_valid;
    logic                       out_ready;
    logic [5:0]                 out_ch;
    logic signed [DT_W-1:0]     out_dt;
    logic                       pending_any;
    logic [3:0]                 fifo_level;
    logic [15:0]                drop_cnt;

    typedef struct {
        int ch;
        int dt;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_err = 0;

    sc_match_serializer_fifo #(
        .N_CH(N_CH), .TIME_W(TIME_W), .DT_W(DT_W), .DEPTH(DEPTH)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .flush         (flush),
        .song_time     (song_time),
        .match_trigger (match_trigger),
        .match_time    (match_time),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_ch        (out_ch),
        .out_dt        (out_dt),
        .pending_any   (pending_any),
        .fifo_level    (fifo_level),
        .drop_cnt      (drop_cnt)
    );

    always #5 clk = ~clk;

    // Monitor: every accepted head record must match the next expected one.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            exp_t e;
            n_vec++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_record: got ch=%0d dt=%0d, expected none",
                         out_ch, out_dt);
            end else begin
                e = exp_q.pop_front();
                if (int'(out_ch) != e.ch || int'(out_dt) != e.dt) begin
                    n_err++;
                    $display("FAIL record: got ch=%0d dt=%0d, expected ch=%0d dt=%0d",
                             out_ch, out_dt, e.ch, e.dt);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic set_trig(input int ch, input int st, input int mt);
        song_time = TIME_W'(st);
        match_time[ch*TIME_W +: TIME_W] = TIME_W'(mt);
        match_trigger[ch] = 1'b1;
    endtask

    task automatic expect_rec(input int ch, input int dt);
        exp_t e;
        e.ch = ch;
        e.dt = dt;
        exp_q.push_back(e);
    endtask

    task automatic single(input int ch, input int st, input int mt);
        match_trigger = '0;
        set_trig(ch, st, mt);
        tick();
        match_trigger = '0;
    endtask

    task automatic wait_drain(input string name);
        int cyc;
        cyc = 0;
        while ((exp_q.size() != 0 || out_valid) && cyc < 200) begin
            tick();
            cyc++;
        end
        n_vec++;
        if (exp_q.size() != 0 || out_valid) begin
            n_err++;
            $display("FAIL %s_drain: got %0d records outstanding, expected 0",
                     name, exp_q.size());
            exp_q.delete();
        end
    endtask

    initial begin
        rst_n         = 1'b0;
        flush         = 1'b0;
        song_time     = '0;
        match_trigger = '0;
        match_time    = '0;
        out_ready     = 1'b1;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();

        chk("rst_out_valid",   int'(out_valid),   0);
        chk("rst_out_ch",      int'(out_ch),      0);
        chk("rst_out_dt",      int'(out_dt),      0);
        chk("rst_pending_any", int'(pending_any), 0);
        chk("rst_fifo_level",  int'(fifo_level),  0);
        chk("rst_drop_cnt",    int'(drop_cnt),    0);

        // 1 single record, two-cycle latency
        expect_rec(5, 10);
        single(5, 1000, 990);
        chk("t1_valid_k",   int'(out_valid),   0);
        chk("t1_pending_k", int'(pending_any), 1);
        tick();
        chk("t1_valid_k1",  int'(out_valid), 1);
        chk("t1_ch_k1",     int'(out_ch),    5);
        chk("t1_dt_k1",     int'(out_dt),    10);
        wait_drain("t1");
        chk("t1_hold_ch",   int'(out_ch), 5);
        chk("t1_hold_dt",   int'(out_dt), 10);

        // 2 simultaneous burst, delivered highest channel first on consecutive cycles
        expect_rec(36, 10);
        expect_rec(3, -5);
        expect_rec(0, 0);
        match_trigger = '0;
        set_trig(36, 500, 490);
        set_trig(3, 500, 505);
        set_trig(0, 500, 500);
        tick();
        match_trigger = '0;
        tick();
        chk("t2_ch_a", int'(out_ch), 36);
        tick();
        chk("t2_valid_b", int'(out_valid), 1);
        chk("t2_ch_b",    int'(out_ch),    3);
        tick();
        chk("t2_valid_c", int'(out_valid), 1);
        chk("t2_ch_c",    int'(out_ch),    0);
        wait_drain("t2");

        // 3 backpressure: 8 buffered, 2 waiting in pending, no loss
        out_ready = 1'b0;
        for (int c = 1; c <= 8; c++) expect_rec(c, c);
        expect_rec(10, 10);
        expect_rec(9, 9);
        for (int c = 1; c <= 10; c++) single(c, 2000, 2000 - c);
        repeat (3) tick();
        chk("t3_level",   int'(fifo_level),  8);
        chk("t3_pending", int'(pending_any), 1);
        chk("t3_drops",   int'(drop_cnt),    0);
        out_ready = 1'b1;
        wait_drain("t3");
        chk("t3_pending_after", int'(pending_any), 0);

        // 4 wrap and negative saturation with 8-bit dt
        expect_rec(20, 4);
        expect_rec(21, -128);
        single(20, 2, 16'hFFFE);
        single(21, 0, 300);
        wait_drain("t4");

        // 5 retrigger while pending behind a full FIFO
        out_ready = 1'b0;
        for (int c = 30; c >= 23; c--) begin
            expect_rec(c, c - 20);
            single(c, 100, 100 - (c - 20));
        end
        expect_rec(7, 10);
        single(7, 100, 90);
        single(7, 100, 50);
        repeat (2) tick();
        chk("t5_drops",   int'(drop_cnt),    1);
        chk("t5_level",   int'(fifo_level),  8);
        chk("t5_pending", int'(pending_any), 1);
        out_ready = 1'b1;
        wait_drain("t5");
        chk("t5_drops_after", int'(drop_cnt), 1);

        // 6 flush with 3 queued + 2 pending, then reset
        out_ready = 1'b0;
        single(1, 0, 0);
        single(2, 0, 0);
        single(3, 0, 0);
        match_trigger = '0;
        set_trig(10, 0, 0);
        set_trig(11, 0, 0);
        tick();
        match_trigger = '0;
        chk("t6_level_pre",   int'(fifo_level),  3);
        chk("t6_pending_pre", int'(pending_any), 1);
        flush = 1'b1;
        set_trig(12, 0, 0);
        tick();
        flush = 1'b0;
        match_trigger = '0;
        chk("t6_valid",   int'(out_valid),   0);
        chk("t6_level",   int'(fifo_level),  0);
        chk("t6_pending", int'(pending_any), 0);
        chk("t6_drops",   int'(drop_cnt),    1);
        chk("t6_ch",      int'(out_ch),      0);
        chk("t6_dt",      int'(out_dt),      0);
        repeat (3) tick();
        chk("t6_valid_later", int'(out_valid), 0);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        chk("t6_rst_drops", int'(drop_cnt),  0);
        chk("t6_rst_valid", int'(out_valid), 0);
        chk("t6_leftover",  exp_q.size(),    0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
